// File: rtl/irrigacao_pkg.sv
// Shared types for the zoned irrigation controller: FSM states, segment glyphs
// and the per-zone watering decision.
package irrigacao_pkg;

    typedef enum logic [2:0] {OCIOSO, AVALIA, GOTEJA, ASPERGE, PAUSA} estadoT;

    // {g,f,e,d,c,b,a}, active-high
    localparam logic [6:0] SEG_0     = 7'b0111111;
    localparam logic [6:0] SEG_1     = 7'b0000110;
    localparam logic [6:0] SEG_2     = 7'b1011011;
    localparam logic [6:0] SEG_3     = 7'b1001111;
    localparam logic [6:0] SEG_E     = 7'b1111001;
    localparam logic [6:0] SEG_G     = 7'b0111101;
    localparam logic [6:0] SEG_A     = 7'b1110111;
    localparam logic [6:0] SEG_TRACO = 7'b1000000;

    // Returns {drip, sprinkle}; the two terms never overlap.
    function automatic logic [1:0] decideZona(input logic solo, input logic ar,
                                              input logic medio, input logic temp);
        decideZona = {~solo & ar & (~medio | temp), ~solo & (~ar | (medio & ~temp))};
    endfunction

endpackage

// File: rtl/filtro_sensor.sv
// One sensor bit: two-flop synchroniser followed by a debounce that accepts a
// new level only after DEBOUNCE_CICLOS consecutive equal samples.
module filtro_sensor #(
    parameter int DEBOUNCE_CICLOS = 16
) (
    input  logic clock,
    input  logic resetN,
    input  logic entrada,
    output logic saida
);
    localparam int CW = $clog2(DEBOUNCE_CICLOS);

    logic          sync1, sync2;
    logic [CW-1:0] cnt;

    // cnt counts samples that disagree with the accepted level; any agreeing sample restarts it
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            cnt   <= '0;
            saida <= 1'b0;
        end else begin
            sync1 <= entrada;
            sync2 <= sync1;
            if (sync2 == saida) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CICLOS - 1)) begin
                cnt   <= '0;
                saida <= sync2;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/controle_irrigacao_zonas.sv
// Round-robin zoned irrigation controller with filtered sensors, tank alarm,
// inlet valve hysteresis and a registered 7-segment status display.
module controle_irrigacao_zonas import irrigacao_pkg::*; #(
    parameter int NUM_ZONAS       = 4,
    parameter int DEBOUNCE_CICLOS = 16,
    parameter int TEMPO_GOTEJ     = 1000,
    parameter int TEMPO_ASPER     = 500
) (
    input  logic                         Clock,
    input  logic                         ResetN,
    input  logic [NUM_ZONAS-1:0]         UmidadeAr,
    input  logic [NUM_ZONAS-1:0]         UmidadeSolo,
    input  logic                         Temperatura,
    input  logic                         High,
    input  logic                         Medium,
    input  logic                         Low,
    input  logic                         ChaveSeletora,
    output logic [NUM_ZONAS-1:0]         Gotejamento,
    output logic [NUM_ZONAS-1:0]         Aspersao,
    output logic                         Erro,
    output logic                         Alarme,
    output logic                         ValvulaEntrada,
    output logic [6:0]                   Segmentos,
    output logic [$clog2(NUM_ZONAS)-1:0] ZonaAtiva
);
    localparam int NF   = 2 * NUM_ZONAS + 4;
    localparam int ZW   = $clog2(NUM_ZONAS);
    localparam int TMAX = (TEMPO_GOTEJ > TEMPO_ASPER) ? TEMPO_GOTEJ : TEMPO_ASPER;
    localparam int CW   = $clog2(TMAX + 1);
    localparam int WW   = $clog2(DEBOUNCE_CICLOS + 3);

    logic [NF-1:0]        brutos, filtrados;
    logic [NUM_ZONAS-1:0] arF, soloF;
    logic                 tempF, altoF, medioF, baixoF;

    assign brutos = {Low, Medium, High, Temperatura, UmidadeSolo, UmidadeAr};

    genvar i;
    generate
        for (i = 0; i < NF; i++) begin : gFiltro
            filtro_sensor #(.DEBOUNCE_CICLOS(DEBOUNCE_CICLOS)) uFiltro (
                .clock  (Clock),
                .resetN (ResetN),
                .entrada(brutos[i]),
                .saida  (filtrados[i])
            );
        end
    endgenerate

    assign arF   = filtrados[NUM_ZONAS-1:0];
    assign soloF = filtrados[2*NUM_ZONAS-1:NUM_ZONAS];
    assign {baixoF, medioF, altoF, tempF} = filtrados[NF-1:2*NUM_ZONAS];

    // Warm-up covers the synchroniser plus debounce so nothing acts on reset-zero filters
    logic [WW-1:0] aquecCnt;
    logic          aquecido;
    assign aquecido = (aquecCnt == WW'(DEBOUNCE_CICLOS + 2));

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN)       aquecCnt <= '0;
        else if (!aquecido) aquecCnt <= aquecCnt + WW'(1);
    end

    logic erroC;
    assign erroC = (altoF & ~medioF) | (medioF & ~baixoF);

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN || !aquecido) begin
            Erro           <= 1'b0;
            Alarme         <= 1'b0;
            ValvulaEntrada <= 1'b0;
        end else begin
            Erro   <= erroC;
            Alarme <= erroC | ~baixoF;
            if (altoF || erroC) ValvulaEntrada <= 1'b0;
            else if (!medioF)   ValvulaEntrada <= 1'b1;
        end
    end

    estadoT        estado, estadoProx;
    logic [ZW-1:0] zonaProx, zonaInc;
    logic [CW-1:0] tempo, tempoProx;
    logic [1:0]    decisao;
    logic [6:0]    segProx;

    assign zonaInc = (ZonaAtiva == ZW'(NUM_ZONAS - 1)) ? '0 : ZonaAtiva + ZW'(1);
    assign decisao = decideZona(soloF[ZonaAtiva], arF[ZonaAtiva], medioF, tempF);

    always_comb begin
        estadoProx = estado;
        zonaProx   = ZonaAtiva;
        tempoProx  = tempo;
        case (estado)
            OCIOSO: if (aquecido) estadoProx = AVALIA;
            AVALIA: begin
                if (Alarme || decisao == 2'b00) begin
                    zonaProx = zonaInc;
                end else if (decisao[1]) begin
                    tempoProx  = CW'(TEMPO_GOTEJ - 1);
                    estadoProx = GOTEJA;
                end else begin
                    tempoProx  = CW'(TEMPO_ASPER - 1);
                    estadoProx = ASPERGE;
                end
            end
            GOTEJA, ASPERGE: begin
                if (Alarme || soloF[ZonaAtiva] || tempo == '0) estadoProx = PAUSA;
                else                                          tempoProx  = tempo - CW'(1);
            end
            PAUSA: begin
                zonaProx   = zonaInc;
                estadoProx = AVALIA;
            end
            default: estadoProx = OCIOSO;
        endcase
    end

    // Display decodes the next state so the glyph lines up with the valve outputs
    always_comb begin
        segProx = SEG_TRACO;
        if (ChaveSeletora) begin
            if (estadoProx == GOTEJA)       segProx = SEG_G;
            else if (estadoProx == ASPERGE) segProx = SEG_A;
        end else if (aquecido && erroC) segProx = SEG_E;
        else if (altoF)                 segProx = SEG_3;
        else if (medioF)                segProx = SEG_2;
        else if (baixoF)                segProx = SEG_1;
        else                            segProx = SEG_0;
    end

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            estado      <= OCIOSO;
            ZonaAtiva   <= '0;
            tempo       <= '0;
            Gotejamento <= '0;
            Aspersao    <= '0;
            Segmentos   <= '0;
        end else begin
            estado      <= estadoProx;
            ZonaAtiva   <= zonaProx;
            tempo       <= tempoProx;
            Gotejamento <= (estadoProx == GOTEJA)  ? (NUM_ZONAS'(1) << zonaProx) : '0;
            Aspersao    <= (estadoProx == ASPERGE) ? (NUM_ZONAS'(1) << zonaProx) : '0;
            Segmentos   <= segProx;
        end
    end

endmodule

// File: tb/tb_controle_irrigacao_zonas.sv
// Directed scenarios plus randomized tank/zone phases checked against rule-level models.
module tb_controle_irrigacao_zonas;
    localparam int NZ = 4, DB = 4, TG = 8, TA = 5;
    localparam logic [6:0] S0 = 7'b0111111, S1 = 7'b0000110, S2 = 7'b1011011, S3 = 7'b1001111;
    localparam logic [6:0] SE = 7'b1111001, SA = 7'b1110111, ST = 7'b1000000;

    logic          Clock, ResetN;
    logic [NZ-1:0] UmidadeAr, UmidadeSolo, Gotejamento, Aspersao;
    logic          Temperatura, High, Medium, Low, ChaveSeletora;
    logic          Erro, Alarme, ValvulaEntrada;
    logic [6:0]    Segmentos;
    logic [1:0]    ZonaAtiva;

    int nChk = 0, nFail = 0;

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    controle_irrigacao_zonas #(.NUM_ZONAS(NZ), .DEBOUNCE_CICLOS(DB), .TEMPO_GOTEJ(TG), .TEMPO_ASPER(TA)) dut (
        .Clock(Clock), .ResetN(ResetN), .UmidadeAr(UmidadeAr), .UmidadeSolo(UmidadeSolo),
        .Temperatura(Temperatura), .High(High), .Medium(Medium), .Low(Low),
        .ChaveSeletora(ChaveSeletora), .Gotejamento(Gotejamento), .Aspersao(Aspersao),
        .Erro(Erro), .Alarme(Alarme), .ValvulaEntrada(ValvulaEntrada),
        .Segmentos(Segmentos), .ZonaAtiva(ZonaAtiva)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChk++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge Clock);
    endtask

    task automatic tanque(input logic h, input logic m, input logic l);
        High = h; Medium = m; Low = l;
    endtask

    function automatic logic [6:0] segNivel(input logic h, input logic m, input logic l);
        if ((h && !m) || (m && !l)) return SE;
        if (h) return S3;
        if (m) return S2;
        if (l) return S1;
        return S0;
    endfunction

    int         n, len;
    logic [1:0] prevZ;
    logic [3:0] acc, dripM, sprM, seenG, seenA;
    logic       accB, okAll, h, m, l, c, e, vM, t;

    initial begin
        ResetN = 1'b0; UmidadeAr = '0; UmidadeSolo = '1; Temperatura = 1'b0;
        tanque(1, 1, 1); ChaveSeletora = 1'b0;
        step(2);
        chk("reset valves", {Gotejamento, Aspersao}, 8'h00);
        chk("reset flags", {Erro, Alarme, ValvulaEntrada}, 3'b000);
        chk("reset seg", Segmentos, 7'h00);
        chk("reset zona", ZonaAtiva, 2'd0);
        ResetN = 1'b1;

        // full tank, all soils wet
        acc = '0;
        for (int i = 0; i < 25; i++) begin step(1); acc |= Gotejamento | Aspersao; end
        chk("wet no valve", acc, 4'h0);
        chk("full seg", Segmentos, S3);
        chk("full inlet", ValvulaEntrada, 1'b0);
        chk("full alarm", {Erro, Alarme}, 2'b00);
        ChaveSeletora = 1'b1; step(1);
        chk("idle mode seg", Segmentos, ST);
        ChaveSeletora = 1'b0;

        // zone 2 drip
        UmidadeSolo = 4'b1011; UmidadeAr = 4'b0100; Temperatura = 1'b1;
        n = 0;
        while (Gotejamento == '0 && n < 60) begin step(1); n++; end
        chk("drip z2 start", Gotejamento, 4'b0100);
        chk("drip z2 zona", ZonaAtiva, 2'd2);
        len = 0;
        while (Gotejamento == 4'b0100 && len < 20) begin step(1); len++; end
        chk("drip z2 length", len, TG);
        chk("drip pause zona", ZonaAtiva, 2'd2);
        step(1);
        chk("after pause zona", ZonaAtiva, 2'd3);
        UmidadeSolo = '1; UmidadeAr = '0; step(30);

        // zone 0 sprinkle, mode display
        UmidadeSolo = 4'b1110; ChaveSeletora = 1'b1;
        n = 0;
        while (Aspersao == '0 && n < 60) begin step(1); n++; end
        chk("spr z0 start", Aspersao, 4'b0001);
        chk("spr seg", Segmentos, SA);
        len = 0;
        while (Aspersao == 4'b0001 && len < 20) begin step(1); len++; end
        chk("spr z0 length", len, TA);
        chk("spr end seg", Segmentos, ST);
        UmidadeSolo = '1; step(30);

        // tank fault aborts zone 1 drip
        UmidadeSolo = 4'b1101; UmidadeAr = 4'b0010; step(8);
        n = 0; prevZ = ZonaAtiva; step(1);
        while (!(ZonaAtiva == 2'd1 && prevZ == 2'd0 && Gotejamento == '0) && n < 80) begin
            prevZ = ZonaAtiva; step(1); n++;
        end
        chk("wait zone1 eval", n < 80, 1'b1);
        tanque(1, 0, 1); ChaveSeletora = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            step(1);
            if (i == 1) chk("drip z1 open", Gotejamento, 4'b0010);
            if (i == 6) chk("erro before latency", Erro, 1'b0);
            if (i == 7) begin
                chk("erro latency", Erro, 1'b1);
                chk("alarm latency", Alarme, 1'b1);
                chk("drip still open", Gotejamento, 4'b0010);
            end
            if (i == 8) chk("alarm abort", Gotejamento, 4'b0000);
        end
        chk("erro seg", Segmentos, SE);
        chk("erro inlet", ValvulaEntrada, 1'b0);
        acc = '0; accB = 1'b1;
        for (int i = 0; i < 8; i++) begin
            prevZ = ZonaAtiva; step(1);
            accB &= (ZonaAtiva == prevZ + 2'd1);
            acc |= Gotejamento | Aspersao;
        end
        chk("alarm zona cycles", accB, 1'b1);
        chk("alarm no valve", acc, 4'h0);
        tanque(1, 1, 1); UmidadeSolo = '1; UmidadeAr = '0; step(30);

        // drain and refill, inlet hysteresis
        tanque(0, 1, 1); step(10);
        chk("H off inlet hold", ValvulaEntrada, 1'b0);
        chk("M level seg", Segmentos, S2);
        tanque(0, 0, 1); step(6);
        chk("M off inlet early", ValvulaEntrada, 1'b0);
        step(1);
        chk("M off inlet set", ValvulaEntrada, 1'b1);
        chk("L level seg", Segmentos, S1);
        tanque(0, 0, 0); step(10);
        chk("empty inlet", ValvulaEntrada, 1'b1);
        chk("empty alarm", {Erro, Alarme}, 2'b01);
        chk("empty seg", Segmentos, S0);
        tanque(0, 0, 1); step(10);
        tanque(0, 1, 1); step(10);
        chk("M on inlet hold", ValvulaEntrada, 1'b1);
        Low = 1'b0; step(2); Low = 1'b1;
        accB = 1'b0;
        for (int i = 0; i < 12; i++) begin step(1); accB |= Erro | Alarme; end
        chk("low glitch ignored", accB, 1'b0);
        tanque(1, 1, 1); step(6);
        chk("H on inlet early", ValvulaEntrada, 1'b1);
        step(1);
        chk("H on inlet clear", ValvulaEntrada, 1'b0);

        // reset during drip on zone 3
        UmidadeSolo = 4'b0111; UmidadeAr = 4'b1000; Temperatura = 1'b1;
        tanque(1, 1, 1);
        n = 0;
        while (Gotejamento == '0 && n < 80) begin step(1); n++; end
        chk("drip z3 start", Gotejamento, 4'b1000);
        ResetN = 1'b0; #1;
        chk("async reset valves", {Gotejamento, Aspersao}, 8'h00);
        chk("async reset flags", {Erro, Alarme, ValvulaEntrada, ZonaAtiva}, 5'b0);
        step(1); ResetN = 1'b1;
        acc = '0; accB = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            step(1);
            acc |= Gotejamento | Aspersao;
            if (i <= 6) accB |= Erro | Alarme | ValvulaEntrada;
        end
        chk("warmup no valve", acc, 4'h0);
        chk("warmup forced flags", accB, 1'b0);
        n = 0;
        while (Gotejamento == '0 && n < 40) begin step(1); n++; end
        chk("drip z3 restart", Gotejamento, 4'b1000);
        UmidadeSolo = '1; UmidadeAr = '0; step(30);
        vM = 1'b0;

        // random tank patterns, soils wet
        for (int k = 0; k < 12; k++) begin
            h = 1'($urandom); m = 1'($urandom); l = 1'($urandom); c = 1'($urandom);
            tanque(h, m, l); ChaveSeletora = c;
            step(10);
            e = (h && !m) || (m && !l);
            if (h || e) vM = 1'b0;
            else if (!m) vM = 1'b1;
            chk("rnd erro", Erro, e);
            chk("rnd alarme", Alarme, e || !l);
            chk("rnd inlet", ValvulaEntrada, vM);
            chk("rnd seg", Segmentos, c ? ST : segNivel(h, m, l));
        end
        ChaveSeletora = 1'b0;

        // random zone sensors, healthy tank
        for (int k = 0; k < 4; k++) begin
            tanque(1'b0, 1'b1, 1'b1); UmidadeSolo = '1; step(15);
            m = 1'($urandom); t = 1'($urandom);
            UmidadeAr = 4'($urandom); UmidadeSolo = 4'($urandom);
            tanque(1'b0, m, 1'b1); Temperatura = t;
            for (int z = 0; z < NZ; z++) begin
                dripM[z] = !UmidadeSolo[z] && UmidadeAr[z] && (!m || t);
                sprM[z]  = !UmidadeSolo[z] && (!UmidadeAr[z] || (m && !t));
            end
            step(8);
            seenG = '0; seenA = '0; okAll = 1'b1;
            for (int i = 0; i < 90; i++) begin
                step(1);
                if (Gotejamento != '0)
                    okAll &= (Gotejamento == (4'b0001 << ZonaAtiva)) && dripM[ZonaAtiva] && (Aspersao == '0);
                if (Aspersao != '0)
                    okAll &= (Aspersao == (4'b0001 << ZonaAtiva)) && sprM[ZonaAtiva];
                seenG |= Gotejamento; seenA |= Aspersao;
            end
            chk("rnd zone legal", okAll, 1'b1);
            chk("rnd drip zones", seenG, dripM);
            chk("rnd spr zones", seenA, sprM);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChk, nFail);
        $finish;
    end

endmodule
